// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: two half adders plus an OR form the full-adder cell,
// and a carry flop closes the loop; one bit-pair per clock, LSB first.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d, res_q, res_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             p, g1, s, g2;

  half_adder u_ha1 (.x(ra_q[0]), .y(rb_q[0]), .s(p), .c(g1));
  half_adder u_ha2 (.x(p),       .y(carry_q), .s(s), .c(g2));

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        carry_d = g1 | g2;
        res_d   = {s, res_q[WIDTH-1:1]};
        ra_d    = {1'b0, ra_q[WIDTH-1:1]};
        rb_d    = {1'b0, rb_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        // Publish only on the final shift so sum/cout never show partial results.
        if (cnt_q == LAST) begin
          sum_d   = res_d;
          cout_d  = carry_d;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed cases, random operands against a+b+cin, and a
// WIDTH=2 exhaustive sweep.
module tb_serial_adder;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start, cin, busy, done, cout;
  logic [W-1:0] a, b, sum;
  logic         start2, cin2, busy2, done2, cout2;
  logic [1:0]   a2, b2, sum2;

  int checks = 0;
  int failures = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called just after the accepting edge; edges = negedges until done seen (bounded).
  task automatic wait_done8(output int edges, output int nbusy);
    edges = 0;
    nbusy = 0;
    while (edges < 40) begin
      @(negedge clk);
      edges++;
      if (busy && done) chk("busy_done_overlap", 32'(1), 32'(0));
      if (busy) nbusy++;
      if (done) break;
    end
  endtask

  task automatic op8(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                     input string tag);
    logic [W:0] exp;
    int e, nb;
    exp = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Scramble inputs: only the accepting edge may capture them.
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    wait_done8(e, nb);
    chk({tag, "_lat"}, 32'(e), 32'(W + 1));
    chk({tag, "_busy"}, 32'(nb), 32'(W));
    chk({tag, "_sum"}, 32'(sum), 32'(exp[W-1:0]));
    chk({tag, "_cout"}, 32'(cout), 32'(exp[W]));
    @(negedge clk);
    chk({tag, "_done_once"}, 32'(done), 32'(0));
  endtask

  initial begin
    int ndone, dk, e;
    logic held;
    logic [2:0] exp2;
    start = 0; a = '0; b = '0; cin = 0;
    start2 = 0; a2 = '0; b2 = '0; cin2 = 0;

    #12;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_sum", 32'(sum), 32'(0));
    chk("rst_cout", 32'(cout), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic cases.
    op8(8'h35, 8'h4A, 1'b0, "t1");
    op8(8'hFF, 8'h01, 1'b0, "t2a");
    op8(8'hFF, 8'hFF, 1'b1, "t2b");
    op8(8'h00, 8'h00, 1'b1, "t2c");

    // start pulse during SHIFT must be ignored.
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 0; start = 1;
    @(posedge clk);
    #1 start = 0;
    ndone = 0; dk = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 3) begin a = 8'hFF; b = 8'hFF; start = 1; end
      if (k == 4) start = 0;
      if (done) begin ndone++; dk = k; end
    end
    chk("t3_ndone", 32'(ndone), 32'(1));
    chk("t3_lat", 32'(dk), 32'(W + 1));
    chk("t3_sum", 32'(sum), 32'h30);
    chk("t3_cout", 32'(cout), 32'(0));

    // Back-to-back: start held through DONE.
    @(negedge clk);
    a = 8'h35; b = 8'h4A; cin = 0; start = 1;
    @(posedge clk);
    #1 start = 0;
    for (int k = 1; k <= W + 1; k++) @(negedge clk);
    chk("t4_done1", 32'(done), 32'(1));
    chk("t4_sum1", 32'(sum), 32'h7F);
    a = 8'h01; b = 8'h02; cin = 0; start = 1;
    @(posedge clk);
    #1 start = 0;
    held = 1'b1;
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      if (k == 1) chk("t4_no_idle", 32'(busy), 32'(1));
      if (k <= W && sum !== 8'h7F) held = 1'b0;
      if (k == W + 1) begin
        chk("t4_done2", 32'(done), 32'(1));
        chk("t4_sum2", 32'(sum), 32'h03);
        chk("t4_cout2", 32'(cout), 32'(0));
      end
    end
    chk("t4_held", 32'(held), 32'(1));

    // Asynchronous reset mid-operation.
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1; start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 32'(0));
    chk("t5_done", 32'(done), 32'(0));
    chk("t5_sum", 32'(sum), 32'(0));
    chk("t5_cout", 32'(cout), 32'(0));
    ndone = 0;
    repeat (3) begin @(negedge clk); if (done) ndone++; end
    rst_n = 1'b1;
    repeat (12) begin @(negedge clk); if (done) ndone++; end
    chk("t5_no_done", 32'(ndone), 32'(0));
    op8(8'hAA, 8'h55, 1'b1, "t5_after");

    // Random operands against plain arithmetic.
    for (int i = 0; i < 30; i++)
      op8(W'($urandom), W'($urandom), 1'($urandom), "rand");

    // WIDTH=2 exhaustive sweep.
    for (int ta = 0; ta < 4; ta++)
      for (int tb = 0; tb < 4; tb++)
        for (int tc = 0; tc < 2; tc++) begin
          exp2 = 3'(ta + tb + tc);
          @(negedge clk);
          a2 = 2'(ta); b2 = 2'(tb); cin2 = 1'(tc); start2 = 1;
          @(posedge clk);
          #1 start2 = 0;
          e = 0;
          while (e < 20) begin
            @(negedge clk);
            e++;
            if (done2) break;
          end
          chk("w2_lat", 32'(e), 32'(3));
          chk("w2_res", 32'({cout2, sum2}), 32'(exp2));
        end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
